// File: rtl/is_pkg_uart_controller.sv
// Shared types and defaults for the UART controller family.
// Holds the receive FSM states, parity modes and the majority-vote helper.
package is_pkg_uart_controller;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_t;

  localparam int OVS_DEF        = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/is_uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only alongside a pop.
// Read data is forced to zero while empty so the head never shows stale contents.
module is_uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   cnt_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (cnt_r == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_r == '0);
  assign count   = cnt_r;
  assign rd_en_s = pop & ~empty;
  assign wr_en_s = push & (~full | rd_en_s);
  assign rdata   = empty ? '0 : mem_r[rd_ptr_r];

  // Storage array; contents are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_r <= cnt_r + (PTR_W+1)'(1);
        2'b01:   cnt_r <= cnt_r - (PTR_W+1)'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/is_uart_rx_core.sv
// Oversampling UART receiver with majority vote, runtime framing, break detection
// and a show-ahead RX FIFO of {par_err, frm_err, data} entries.
module is_uart_rx_core
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_W      = 8,
  parameter int OVS         = OVS_DEF,
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_W-1:0]              baud_div_i,
  input  logic [1:0]                    parity_mode_i,
  input  logic                          stop2_i,
  input  logic                          rxd_i,
  input  logic                          rx_ready_i,
  input  logic                          clr_i,
  output logic                          rx_valid_o,
  output logic [DATA_W-1:0]             rx_data_o,
  output logic                          rx_frm_err_o,
  output logic                          rx_par_err_o,
  output logic                          break_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int OS_W = $clog2(OVS);
  localparam int BC_W = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] sync_r;
  rx_state_t              state_r, state_s;
  logic [DIV_W-1:0]       div_r, tick_cnt_r;
  logic [OS_W-1:0]        os_cnt_r;
  logic [BC_W-1:0]        bit_cnt_r;
  logic [DATA_W-1:0]      shift_r;
  parity_mode_t           par_mode_r;
  logic                   stop2_r, smp0_r, smp1_r, par_err_r, frm_err_r;
  logic                   push_r, break_r, overrun_r;
  logic [DATA_W+1:0]      push_data_r, head_s;
  logic                   rxd_s, start_s, tick_s, bit_end_s, vote_tick_s, vote_s;
  logic                   frm_now_s, push_s, pop_s, fifo_full_s, fifo_empty_s;

  assign rxd_s       = sync_r[SYNC_STAGES-1];
  assign start_s     = (state_r == IDLE) & ~rxd_s;
  assign tick_s      = (state_r != IDLE) & (tick_cnt_r == div_r);
  assign bit_end_s   = tick_s & (os_cnt_r == OS_W'(OVS-1));
  assign vote_tick_s = tick_s & (os_cnt_r == OS_W'(OVS/2+1));
  assign vote_s      = maj3(smp0_r, smp1_r, rxd_s);
  assign frm_now_s   = frm_err_r | ~vote_s;

  // Line synchroniser, idles high.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_r <= '1;
    else       sync_r <= {sync_r[SYNC_STAGES-2:0], rxd_i};
  end

  // Baud tick and oversample position, restarted on each start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_s || state_r == IDLE) begin
      tick_cnt_r <= '0;
      os_cnt_r   <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      os_cnt_r   <= bit_end_s ? '0 : os_cnt_r + OS_W'(1);
    end else begin
      tick_cnt_r <= tick_cnt_r + DIV_W'(1);
    end
  end

  // The first two of the three mid-bit samples; the third is the live line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp0_r <= 1'b1;
      smp1_r <= 1'b1;
    end else begin
      if (tick_s && os_cnt_r == OS_W'(OVS/2-1)) smp0_r <= rxd_s;
      if (tick_s && os_cnt_r == OS_W'(OVS/2))   smp1_r <= rxd_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next state; the frame is handed off at the vote of its last stop bit.
  always_comb begin
    state_s = state_r;
    push_s  = 1'b0;
    case (state_r)
      IDLE:    if (!rxd_s) state_s = START; else state_s = IDLE;
      START: begin
        if (vote_tick_s && vote_s) state_s = IDLE;
        else if (bit_end_s)        state_s = DATA;
        else                       state_s = START;
      end
      DATA: begin
        if (bit_end_s && bit_cnt_r == BC_W'(DATA_W-1))
          state_s = (par_mode_r == PAR_EVEN || par_mode_r == PAR_ODD) ? PARITY : STOP;
        else
          state_s = DATA;
      end
      PARITY:  if (bit_end_s) state_s = STOP; else state_s = PARITY;
      STOP: begin
        if (vote_tick_s && (!stop2_r || bit_cnt_r == BC_W'(1))) begin
          push_s  = 1'b1;
          state_s = rxd_s ? IDLE : WAIT_HI;
        end else begin
          state_s = STOP;
        end
      end
      WAIT_HI: if (rxd_s) state_s = IDLE; else state_s = WAIT_HI;
      default: state_s = IDLE;
    endcase
  end

  // Frame datapath: mode latch, shifter, bit counter and error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_r      <= '0;
      par_mode_r <= PAR_NONE;
      stop2_r    <= 1'b0;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
    end else if (start_s) begin
      div_r      <= baud_div_i;
      par_mode_r <= parity_mode_t'(parity_mode_i);
      stop2_r    <= stop2_i;
      bit_cnt_r  <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
    end else begin
      if (vote_tick_s && state_r == DATA)   shift_r   <= {vote_s, shift_r[DATA_W-1:1]};
      if (vote_tick_s && state_r == PARITY) par_err_r <= (^shift_r) ^ vote_s ^ (par_mode_r == PAR_ODD);
      if (vote_tick_s && state_r == STOP)   frm_err_r <= frm_now_s;
      // Counter restarts whenever a bit boundary also changes state.
      if (bit_end_s) bit_cnt_r <= (state_s != state_r) ? '0 : bit_cnt_r + BC_W'(1);
    end
  end

  // Registered hand-off into the FIFO, with the break flag aligned to it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      push_r      <= 1'b0;
      push_data_r <= '0;
      break_r     <= 1'b0;
    end else begin
      push_r  <= push_s;
      break_r <= push_s & frm_now_s & (shift_r == '0);
      if (push_s) push_data_r <= {par_err_r, frm_now_s, shift_r};
    end
  end

  assign pop_s = ~fifo_empty_s & rx_ready_i;

  // Sticky overrun; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               overrun_r <= 1'b0;
    else if (push_r && fifo_full_s && !pop_s) overrun_r <= 1'b1;
    else if (clr_i)                          overrun_r <= 1'b0;
    else                                     overrun_r <= overrun_r;
  end

  is_uart_sync_fifo #(
    .WIDTH (DATA_W+2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_r),
    .wdata (push_data_r),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_cnt_o)
  );

  assign rx_valid_o   = ~fifo_empty_s;
  assign rx_data_o    = head_s[DATA_W-1:0];
  assign rx_frm_err_o = head_s[DATA_W];
  assign rx_par_err_o = head_s[DATA_W+1];
  assign break_o      = break_r;
  assign overrun_o    = overrun_r;

endmodule
